// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational 8-bit ALU.
// Round-robin between requesters; one command in flight: IDLE -> ISSUE -> RESP.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid_i,
  input  logic [15:0] req_a_i,
  input  logic [15:0] req_b_i,
  input  logic [5:0]  req_op_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [7:0]  alu_a_o,
  output logic [7:0]  alu_b_o,
  output logic [2:0]  alu_op_o,
  input  logic [7:0]  alu_res_i,
  output logic        busy_o,
  output logic [1:0]  dbg_state_o,
  output logic        dbg_prio_o
);

  // Handshake: a command transfers on a cycle where req_valid_i[n] and
  // req_ready_o[n] are both high; a result transfers where rsp_valid_o[owner]
  // and rsp_ready_i[owner] are both high. Valid/data hold until that transfer.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       prio_q;
  logic       owner_q;
  logic [7:0] a_q, b_q, res_q;
  logic [2:0] op_q;

  logic       winner;
  logic       accept;
  logic       rsp_done;

  // Priority only matters under contention; a lone requester always wins.
  assign winner   = (req_valid_i == 2'b11) ? prio_q : req_valid_i[1];
  assign accept   = (state_q == IDLE) && (|req_valid_i) && reset_n;
  assign rsp_done = (state_q == RESP) && rsp_ready_i[owner_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 2'b00;
    rsp_valid_o = 2'b00;
    rsp_data_o  = 8'h00;
    alu_a_o     = 8'h00;
    alu_b_o     = 8'h00;
    alu_op_o    = 3'b000;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_ready_o[winner] = 1'b1;
          state_d             = ISSUE;
        end
      end
      ISSUE: begin
        alu_a_o  = a_q;
        alu_b_o  = b_q;
        alu_op_o = op_q;
        state_d  = RESP;
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        rsp_data_o           = res_q;
        if (rsp_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      op_q    <= 3'b000;
      res_q   <= 8'h00;
    end else begin
      if (accept) begin
        owner_q <= winner;
        a_q     <= winner ? req_a_i[15:8] : req_a_i[7:0];
        b_q     <= winner ? req_b_i[15:8] : req_b_i[7:0];
        op_q    <= winner ? req_op_i[5:3] : req_op_i[2:0];
      end
      if (state_q == ISSUE) begin
        res_q <= alu_res_i;
      end
      // Last-served requester drops to lowest priority.
      if (rsp_done) begin
        prio_q <= ~owner_q;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;
  assign dbg_prio_o  = prio_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; the ALU is modelled as a XOR b.
module tb_alu_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid_i;
  logic [15:0] req_a_i;
  logic [15:0] req_b_i;
  logic [5:0]  req_op_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  rsp_valid_o;
  logic [7:0]  rsp_data_o;
  logic [1:0]  rsp_ready_i;
  logic [7:0]  alu_a_o;
  logic [7:0]  alu_b_o;
  logic [2:0]  alu_op_o;
  logic [7:0]  alu_res_i;
  logic        busy_o;
  logic [1:0]  dbg_state_o;
  logic        dbg_prio_o;

  int n_vec;
  int n_err;
  int n_rsp;

  alu_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_op_i    (req_op_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_ready_i (rsp_ready_i),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_op_o    (alu_op_o),
    .alu_res_i   (alu_res_i),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state_o),
    .dbg_prio_o  (dbg_prio_o)
  );

  assign alu_res_i = alu_a_o ^ alu_b_o;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns 2 time units after the rising edge, i.e. at the start of a cycle.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req_valid_i = 2'b00;
    req_a_i     = 16'h0000;
    req_b_i     = 16'h0000;
    req_op_i    = 6'b000000;
    rsp_ready_i = 2'b00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    req_valid_i = 2'b11;
    #1;
    check("rst_req_ready", {14'd0, req_ready_o}, 16'h0);
    check("rst_rsp_valid", {14'd0, rsp_valid_o}, 16'h0);
    check("rst_busy", {15'd0, busy_o}, 16'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    req_valid_i = 2'b00;
    reset_n     = 1'b1;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    n_rsp   = 0;
    reset_n = 1'b0;
    idle_inputs();

    // single request from requester 0
    do_reset();
    req_valid_i = 2'b01; req_a_i = 16'h00FF; req_b_i = 16'h0055;
    req_op_i = 6'b000000; rsp_ready_i = 2'b01;
    #1;
    check("t1_ready", {14'd0, req_ready_o}, 16'h0001);
    check("t1_busy_idle", {15'd0, busy_o}, 16'h0);
    check("t1_alu_a_idle", {8'd0, alu_a_o}, 16'h0);
    check("t1_data_idle", {8'd0, rsp_data_o}, 16'h0);
    next_cycle(); req_valid_i = 2'b00; #1;
    check("t1_state_issue", {14'd0, dbg_state_o}, 16'h0001);
    check("t1_alu_a", {8'd0, alu_a_o}, 16'h00FF);
    check("t1_alu_b", {8'd0, alu_b_o}, 16'h0055);
    check("t1_ready_issue", {14'd0, req_ready_o}, 16'h0);
    next_cycle(); #1;
    check("t1_rsp_valid", {14'd0, rsp_valid_o}, 16'h0001);
    check("t1_rsp_data", {8'd0, rsp_data_o}, 16'h00AA);
    check("t1_alu_a_resp", {8'd0, alu_a_o}, 16'h0);
    next_cycle(); #1;
    check("t1_done_valid", {14'd0, rsp_valid_o}, 16'h0);
    check("t1_done_busy", {15'd0, busy_o}, 16'h0);
    check("t1_prio", {15'd0, dbg_prio_o}, 16'h0001);

    // simultaneous requests after reset
    do_reset();
    req_valid_i = 2'b11; req_a_i = 16'h075E; req_b_i = 16'h7007; rsp_ready_i = 2'b11;
    #1;
    check("t2_ready0", {14'd0, req_ready_o}, 16'h0001);
    next_cycle(); #1;
    check("t2_alu_a0", {8'd0, alu_a_o}, 16'h005E);
    next_cycle(); #1;
    check("t2_rsp_valid0", {14'd0, rsp_valid_o}, 16'h0001);
    check("t2_rsp_data0", {8'd0, rsp_data_o}, 16'h0059);
    next_cycle(); #1;
    check("t2_ready1", {14'd0, req_ready_o}, 16'h0002);
    next_cycle(); #1;
    check("t2_alu_a1", {8'd0, alu_a_o}, 16'h0007);
    next_cycle(); req_valid_i = 2'b00; #1;
    check("t2_rsp_valid1", {14'd0, rsp_valid_o}, 16'h0002);
    check("t2_rsp_data1", {8'd0, rsp_data_o}, 16'h0077);
    next_cycle(); #1;
    check("t2_prio", {15'd0, dbg_prio_o}, 16'h0);
    check("t2_busy", {15'd0, busy_o}, 16'h0);

    // response stall; non-owner ready must be ignored
    req_valid_i = 2'b10; req_a_i = 16'h3C00; req_b_i = 16'h0F00; rsp_ready_i = 2'b00;
    #1;
    check("t3_ready", {14'd0, req_ready_o}, 16'h0002);
    next_cycle(); req_valid_i = 2'b11; #1;
    check("t3_state_issue", {14'd0, dbg_state_o}, 16'h0001);
    for (int k = 0; k < 5; k++) begin
      next_cycle(); rsp_ready_i = 2'b01; #1;
      check("t3_stall_valid", {14'd0, rsp_valid_o}, 16'h0002);
      check("t3_stall_data", {8'd0, rsp_data_o}, 16'h0033);
      check("t3_stall_ready", {14'd0, req_ready_o}, 16'h0);
    end
    next_cycle(); rsp_ready_i = 2'b10; #1;
    check("t3_final_valid", {14'd0, rsp_valid_o}, 16'h0002);
    check("t3_final_data", {8'd0, rsp_data_o}, 16'h0033);
    next_cycle(); req_valid_i = 2'b00; rsp_ready_i = 2'b00; #1;
    check("t3_done_state", {14'd0, dbg_state_o}, 16'h0);
    check("t3_done_valid", {14'd0, rsp_valid_o}, 16'h0);
    check("t3_prio", {15'd0, dbg_prio_o}, 16'h0);

    // continuous contention for 12 cycles
    req_valid_i = 2'b11; req_a_i = 16'h1122; req_b_i = 16'h0102;
    req_op_i = 6'b010101; rsp_ready_i = 2'b11;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) next_cycle();
      #1;
      if (rsp_valid_o != 2'b00) n_rsp++;
      if (k % 3 == 0) begin
        check("t4_grant", {14'd0, req_ready_o}, ((k / 3) % 2 == 1) ? 16'h0002 : 16'h0001);
        check("t4_busy_acc", {15'd0, busy_o}, 16'h0);
      end else if (k % 3 == 1) begin
        check("t4_busy_issue", {15'd0, busy_o}, 16'h0001);
        check("t4_alu_op", {13'd0, alu_op_o}, ((k / 3) % 2 == 1) ? 16'h0002 : 16'h0005);
        check("t4_alu_a", {8'd0, alu_a_o}, ((k / 3) % 2 == 1) ? 16'h0011 : 16'h0022);
      end else begin
        check("t4_busy_resp", {15'd0, busy_o}, 16'h0001);
        check("t4_rsp_valid", {14'd0, rsp_valid_o}, ((k / 3) % 2 == 1) ? 16'h0002 : 16'h0001);
        check("t4_rsp_data", {8'd0, rsp_data_o}, ((k / 3) % 2 == 1) ? 16'h0010 : 16'h0020);
      end
    end
    next_cycle(); req_valid_i = 2'b00; #1;
    check("t4_rsp_count", n_rsp[15:0], 16'd4);
    check("t4_prio", {15'd0, dbg_prio_o}, 16'h0);
    check("t4_end_busy", {15'd0, busy_o}, 16'h0);

    // reset asserted while responding to requester 1
    req_valid_i = 2'b10; req_a_i = 16'hA000; req_b_i = 16'h0500; req_op_i = 6'b000000;
    rsp_ready_i = 2'b00;
    #1;
    check("t5_ready", {14'd0, req_ready_o}, 16'h0002);
    next_cycle(); req_valid_i = 2'b00; #1;
    next_cycle(); #1;
    check("t5_rsp_valid", {14'd0, rsp_valid_o}, 16'h0002);
    check("t5_rsp_data", {8'd0, rsp_data_o}, 16'h00A5);
    reset_n = 1'b0; req_valid_i = 2'b11;
    #1;
    check("t5_rst_valid", {14'd0, rsp_valid_o}, 16'h0);
    check("t5_rst_data", {8'd0, rsp_data_o}, 16'h0);
    check("t5_rst_busy", {15'd0, busy_o}, 16'h0);
    check("t5_rst_ready", {14'd0, req_ready_o}, 16'h0);
    next_cycle(); reset_n = 1'b1; req_valid_i = 2'b00; rsp_ready_i = 2'b10; #1;
    check("t5_post_valid", {14'd0, rsp_valid_o}, 16'h0);
    check("t5_post_prio", {15'd0, dbg_prio_o}, 16'h0);
    next_cycle(); #1;
    check("t5_post_valid2", {14'd0, rsp_valid_o}, 16'h0);
    req_valid_i = 2'b11; #1;
    check("t5_post_grant", {14'd0, req_ready_o}, 16'h0001);
    req_valid_i = 2'b00;
    next_cycle();

    // opcode pass-through from requester 1
    req_valid_i = 2'b10; req_a_i = 16'hFF00; req_b_i = 16'hFF00; req_op_i = 6'b111000;
    rsp_ready_i = 2'b10;
    #1;
    check("t6_ready", {14'd0, req_ready_o}, 16'h0002);
    check("t6_op_idle", {13'd0, alu_op_o}, 16'h0);
    next_cycle(); req_valid_i = 2'b00; #1;
    check("t6_op_issue", {13'd0, alu_op_o}, 16'h0007);
    check("t6_alu_a", {8'd0, alu_a_o}, 16'h00FF);
    next_cycle(); #1;
    check("t6_op_resp", {13'd0, alu_op_o}, 16'h0);
    check("t6_rsp_valid", {14'd0, rsp_valid_o}, 16'h0002);
    check("t6_rsp_data", {8'd0, rsp_data_o}, 16'h0000);
    next_cycle(); #1;
    check("t6_done_busy", {15'd0, busy_o}, 16'h0);
    check("t6_prio", {15'd0, dbg_prio_o}, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports `clk` and `reset_n`.
REQ-002 `clk`  input  1  rising-edge clock for all state.
REQ-003 `reset_n`  input  1  asynchronous active-low reset.
REQ-004 `req_valid_i`  input  2  per-requester command valid; bit n belongs to requester n.
REQ-005 `req_a_i`  input  16  operand A; requester n uses bits [8n+7:8n].
REQ-006 `req_b_i`  input  16  operand B; same packing as `req_a_i`.
REQ-007 `req_op_i`  input  6  opcode; requester n uses bits [3n+2:3n].
REQ-008 `req_ready_o`  output  2  command accepted when `req_valid_i[n]` and `req_ready_o[n]` are both high.
REQ-009 `rsp_valid_o`  output  2  result valid for requester n.
REQ-010 `rsp_data_o`  output  8  result, shared by both requesters; meaningful only while a `rsp_valid_o` bit is high.
REQ-011 `rsp_ready_i`  input  2  requester n consumes the result.
REQ-012 `alu_a_o`, `alu_b_o`  output  8 each  operands to the shared combinational 8-bit ALU.
REQ-013 `alu_op_o`  output  3  ALU opcode; passed through unmodified.
REQ-014 `alu_res_i`  input  8  ALU result, combinational from `alu_*_o`.
REQ-015 `busy_o`  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-017 IDLE SHALL select a winner:
- only one `req_valid_i` bit high: that requester wins.
- both high: requester `prio` wins, where `prio` is a 1-bit priority register.
REQ-018 IDLE SHALL assert `req_ready_o` only for the winner, combinationally; the other bit and all bits with no valid SHALL be 0.
REQ-019 On acceptance the block SHALL:
- latch the winner's a, b and op into internal registers;
- latch the winner's index in `owner`;
- move to ISSUE.
REQ-020 ISSUE SHALL:
- drive `alu_a_o`, `alu_b_o` and `alu_op_o` from the latched registers;
- capture `alu_res_i` into the result register at the clock edge;
- move unconditionally to RESP.
REQ-021 Outside ISSUE, `alu_a_o`, `alu_b_o` and `alu_op_o` SHALL be 0.
REQ-022 RESP SHALL:
- assert `rsp_valid_o[owner]` only;
- hold `rsp_data_o` and `rsp_valid_o` stable until `rsp_ready_i[owner]` is high;
- then return to IDLE the next cycle.
REQ-023 `rsp_ready_i[~owner]` SHALL be ignored.
REQ-024 `rsp_data_o` SHALL be 0 whenever `rsp_valid_o` is 0.
REQ-025 On response completion, `prio` SHALL be set to `~owner`: round-robin, with the last-served requester at lowest priority.
REQ-026 Latency SHALL be as follows:
- acceptance in cycle T;
- ISSUE in cycle T+1;
- `rsp_valid_o` high from cycle T+2.
- Minimum issue interval is 3 cycles per command with zero response stall.
REQ-027 No command SHALL be accepted while in ISSUE or RESP; `req_ready_o` SHALL be 2'b00 in those states.
REQ-028 A request that is withdrawn before acceptance SHALL leave no trace; requests SHALL NOT be queued.
REQ-029 Opcode and operand values SHALL NOT be interpreted or range-checked; all 8 opcodes SHALL be passed through.
REQ-030 A response stall of any length SHALL NOT change `prio`, `owner` or the result register.

Reset
REQ-031 While `reset_n` is low, asynchronously:
- state is IDLE, `prio`=0, `owner`=0;
- operand, opcode and result registers are 0;
- all outputs are 0.
REQ-032 Assertion of reset mid-transaction (ISSUE or RESP) SHALL discard that transaction; no response SHALL be produced after release.
REQ-033 After reset release, the first cycle SHALL behave as IDLE with `prio`=0.

Verification
REQ-034 Bench model: `alu_res_i` = `alu_a_o` XOR `alu_b_o`.
- Single request: requester 0 sends a=8'hFF, b=8'h55, op=3'b000.
  - Response: `req_ready_o`=2'b01 at T; `alu_a_o`=8'hFF at T+1; `rsp_valid_o`=2'b01 and `rsp_data_o`=8'hAA at T+2.
REQ-035 Simultaneous requests after reset:
- requester 0 sends a=8'h5E, b=8'h07; requester 1 sends a=8'h07, b=8'h70; both held valid.
  - Response: requester 0 is served first with 8'h59; requester 1 is accepted next with 8'h77.
  - After both: `prio`=0.
REQ-036 Response stall: `rsp_ready_i`=0 for 5 cycles in RESP.
- Response: `rsp_valid_o` and `rsp_data_o` held constant; `req_ready_o`=2'b00 throughout; completion 1 cycle after `rsp_ready_i` rises.
REQ-037 Continuous contention: both requesters always valid for 12 cycles.
- Response: grants alternate 0,1,0,1; exactly 4 responses; `busy_o` low only in the acceptance cycles.
REQ-038 Reset in RESP: `reset_n` pulsed low while `rsp_valid_o`=2'b10.
- Response: all outputs 0 immediately; after release, `rsp_valid_o` stays 0 and `prio`=0.
REQ-039 Opcode pass-through: requester 1 sends op 3'b111, a=b=8'hFF.
- Response: `alu_op_o`=3'b111 during ISSUE only; `rsp_data_o`=8'h00.
